// File: rtl/inv_round_core.sv
// One AES inverse-cipher round: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
// with InvSubBytes spread over 16/SBOX_PER_CYCLE beats. The mix-column stage is skipped on the last round.
module inv_mix_cols (
  input  logic [127:0] i_state,
  output logic [127:0] o_state
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gm(a0, 4'he) ^ gm(a1, 4'hb) ^ gm(a2, 4'hd) ^ gm(a3, 4'h9),
            gm(a0, 4'h9) ^ gm(a1, 4'he) ^ gm(a2, 4'hb) ^ gm(a3, 4'hd),
            gm(a0, 4'hd) ^ gm(a1, 4'h9) ^ gm(a2, 4'he) ^ gm(a3, 4'hb),
            gm(a0, 4'hb) ^ gm(a1, 4'hd) ^ gm(a2, 4'h9) ^ gm(a3, 4'he)};
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign o_state[127-32*c -: 32] = mix_col(i_state[127-32*c -: 32]);
  end
endmodule

module inv_round_core #(
  parameter int SBOX_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_last,
  input  logic         abort,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [1:0]   dbg_state
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and data is held stable while valid is high and ready low.
  localparam int K  = 16 / SBOX_PER_CYCLE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SUB = 2'd1, S_HOLD = 2'd2} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_work, r_key, r_out_data;
  logic          r_last, r_out_valid;
  logic [127:0]  w_sub, w_t, w_mix;
  logic          w_last_beat;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[2047-8*int'(x) -: 8];
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  always_comb begin
    w_sub = r_work;
    for (int j = 0; j < SBOX_PER_CYCLE; j++) begin
      int idx;
      idx = int'(r_cnt) * SBOX_PER_CYCLE + j;
      w_sub[127-8*idx -: 8] = inv_sbox(r_work[127-8*idx -: 8]);
    end
  end

  assign w_t         = w_sub ^ r_key;
  assign w_last_beat = (r_state == S_SUB) && (r_cnt == CW'(K-1));

  inv_mix_cols u_mix (
    .i_state (w_t),
    .o_state (w_mix)
  );

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (in_valid)    w_next = S_SUB;
        S_SUB:   if (w_last_beat) w_next = S_HOLD;
        S_HOLD:  if (out_ready)   w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // abort clears control only; out_data keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_work      <= '0;
      r_key       <= '0;
      r_last      <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (abort) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_work <= inv_shift_rows(in_data);
          r_key  <= in_key;
          r_last <= in_last;
          r_cnt  <= '0;
        end
        S_SUB: begin
          r_work <= w_sub;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last_beat) begin
            r_out_data  <= r_last ? w_t : w_mix;
            r_out_valid <= 1'b1;
          end
        end
        S_HOLD: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign dbg_state = r_state;
endmodule
